// File: rtl/display_pkg.sv
// Shared display types and constants for the 640x480 pixel pipeline.
// Holds resolution, colour width, pattern modes, the RGB struct and the bar palette.
package display_pkg;

   localparam int H_RES = 640;
   localparam int V_RES = 480;
   localparam int CW    = 4;

   typedef enum logic [1:0] {
      BARS    = 2'd0,
      CHECKER = 2'd1,
      SQUARE  = 2'd2,
      GREY    = 2'd3
   } pattern_mode_t;

   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } rgb_t;

   localparam rgb_t C_WHITE   = 12'hFFF;
   localparam rgb_t C_YELLOW  = 12'hFF0;
   localparam rgb_t C_CYAN    = 12'h0FF;
   localparam rgb_t C_GREEN   = 12'h0F0;
   localparam rgb_t C_MAGENTA = 12'hF0F;
   localparam rgb_t C_RED     = 12'hF00;
   localparam rgb_t C_BLUE    = 12'h00F;
   localparam rgb_t C_BLACK   = 12'h000;
   localparam rgb_t C_SQ_BG   = 12'h137;
   localparam rgb_t C_GREY    = 12'h888;
   localparam rgb_t C_GRID    = 12'h444;

   localparam rgb_t BAR_COLOUR [8] = '{C_WHITE, C_YELLOW, C_CYAN, C_GREEN,
                                       C_MAGENTA, C_RED, C_BLUE, C_BLACK};

   // Bar number is the count of bar boundaries at or left of x.
   function automatic logic [2:0] bar_index(input logic [9:0] x, input logic [9:0] bw);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (x >= 10'(i) * bw) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/square_mover.sv
// Bouncing-square position: steps qx/qy by Q_SPEED on each update strobe,
// reversing direction and clamping at the screen edges so it never wraps.
module square_mover #(
   parameter int H_RES   = display_pkg::H_RES,
   parameter int V_RES   = display_pkg::V_RES,
   parameter int Q_SIZE  = 32,
   parameter int Q_SPEED = 2
) (
   input  logic       clk_pix,
   input  logic       rst,
   input  logic       step,
   output logic [9:0] qx,
   output logic [9:0] qy
);

   localparam logic [9:0] X_MAX = 10'(H_RES - Q_SIZE);
   localparam logic [9:0] Y_MAX = 10'(V_RES - Q_SIZE);
   localparam logic [9:0] SPD   = 10'(Q_SPEED);

   logic dx;
   logic dy;

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         qx <= '0;
         qy <= '0;
         dx <= 1'b1;
         dy <= 1'b1;
      end else if (step) begin
         if (dx) begin
            if (qx + SPD >= X_MAX) begin
               qx <= X_MAX;
               dx <= 1'b0;
            end else begin
               qx <= qx + SPD;
            end
         end else if (qx <= SPD) begin
            qx <= '0;
            dx <= 1'b1;
         end else begin
            qx <= qx - SPD;
         end

         if (dy) begin
            if (qy + SPD >= Y_MAX) begin
               qy <= Y_MAX;
               dy <= 1'b0;
            end else begin
               qy <= qy + SPD;
            end
         end else if (qy <= SPD) begin
            qy <= '0;
            dy <= 1'b1;
         end else begin
            qy <= qy - SPD;
         end
      end
   end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator: two-stage pipeline from display timings to VGA/DVI pins.
// Define PATTERN_GRID_EN to overlay a 32-pixel grey alignment grid in every mode.
module pattern_gen #(
   parameter int H_RES   = display_pkg::H_RES,
   parameter int V_RES   = display_pkg::V_RES,
   parameter int Q_SIZE  = 32,
   parameter int Q_SPEED = 2
) (
   input  logic       clk_pix,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic [9:0] sx,
   input  logic [9:0] sy,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       de,
   output logic       vga_hsync,
   output logic       vga_vsync,
   output logic       vga_de,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       frame
);

   import display_pkg::*;

   localparam logic [9:0] BAR_W = 10'(H_RES / 8);
   localparam logic [9:0] QS    = 10'(Q_SIZE);

   pattern_mode_t mode_q;
   logic [9:0]    qx;
   logic [9:0]    qy;
   logic          update;
   logic          in_sq;
   rgb_t          raw;
   rgb_t          c1;
   logic          hs1;
   logic          vs1;
   logic          de1;

   // First blanking line start: the only point where mode and animation change.
   assign update = (sx == 10'd0) && (sy == 10'(V_RES));

   square_mover #(
      .H_RES   (H_RES),
      .V_RES   (V_RES),
      .Q_SIZE  (Q_SIZE),
      .Q_SPEED (Q_SPEED)
   ) u_mover (
      .clk_pix (clk_pix),
      .rst     (rst),
      .step    (update),
      .qx      (qx),
      .qy      (qy)
   );

   assign in_sq = (sx >= qx) && (sx < qx + QS) && (sy >= qy) && (sy < qy + QS);

   always_comb begin
      raw = C_BLACK;
      case (mode_q)
         BARS:    raw = BAR_COLOUR[bar_index(sx, BAR_W)];
         CHECKER: raw = (sx[5] ^ sy[5]) ? C_WHITE : C_BLACK;
         SQUARE:  raw = in_sq ? C_WHITE : C_SQ_BG;
         GREY:    raw = C_GREY;
         default: raw = C_BLACK;
      endcase
`ifdef PATTERN_GRID_EN
      if ((sx[4:0] == 5'd0) || (sy[4:0] == 5'd0)) raw = C_GRID;
`else
`endif
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         mode_q    <= BARS;
         frame     <= 1'b0;
         c1        <= C_BLACK;
         hs1       <= 1'b1;
         vs1       <= 1'b1;
         de1       <= 1'b0;
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
         vga_de    <= 1'b0;
         vga_r     <= '0;
         vga_g     <= '0;
         vga_b     <= '0;
      end else begin
         if (update) mode_q <= pattern_mode_t'(mode);
         frame     <= update;
         c1        <= raw;
         hs1       <= hsync;
         vs1       <= vsync;
         de1       <= de;
         vga_hsync <= hs1;
         vga_vsync <= vs1;
         vga_de    <= de1;
         {vga_r, vga_g, vga_b} <= de1 ? c1 : C_BLACK;
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: hand-computed pixels, sync alignment, bounce and reset.
// Frame update points are driven directly instead of running full 800x525 frames.
module tb_pattern_gen;

   logic       clk_pix = 1'b0;
   logic       rst;
   logic [1:0] mode;
   logic [9:0] sx;
   logic [9:0] sy;
   logic       hsync;
   logic       vsync;
   logic       de;
   logic       vga_hsync;
   logic       vga_vsync;
   logic       vga_de;
   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       frame;

   int n_tests = 0;
   int n_fail  = 0;
   int mqx, mqy;
   bit mdx, mdy;
   int ticks = 0;

   logic hs_h [0:801];
   logic vs_h [0:801];
   logic de_h [0:801];

   always #5 clk_pix = ~clk_pix;

   pattern_gen dut (
      .clk_pix   (clk_pix),
      .rst       (rst),
      .mode      (mode),
      .sx        (sx),
      .sy        (sy),
      .hsync     (hsync),
      .vsync     (vsync),
      .de        (de),
      .vga_hsync (vga_hsync),
      .vga_vsync (vga_vsync),
      .vga_de    (vga_de),
      .vga_r     (vga_r),
      .vga_g     (vga_g),
      .vga_b     (vga_b),
      .frame     (frame)
   );

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic idle();
      sx = 10'd700; sy = 10'd10; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
   endtask

   task automatic model_reset();
      mqx = 0; mqy = 0; mdx = 1'b1; mdy = 1'b1;
   endtask

   task automatic model_step();
      if (mdx) begin
         if (mqx + 2 >= 608) begin mqx = 608; mdx = 1'b0; end
         else mqx = mqx + 2;
      end else if (mqx <= 2) begin mqx = 0; mdx = 1'b1; end
      else mqx = mqx - 2;
      if (mdy) begin
         if (mqy + 2 >= 448) begin mqy = 448; mdy = 1'b0; end
         else mqy = mqy + 2;
      end else if (mqy <= 2) begin mqy = 0; mdy = 1'b1; end
      else mqy = mqy - 2;
   endtask

   // Present one active pixel; colour appears two edges later.
   task automatic check_pix(input string tag, input int x, input int y, input logic [11:0] exp_in);
      logic [11:0] e;
      e = exp_in;
`ifdef PATTERN_GRID_EN
      if ((x % 32 == 0) || (y % 32 == 0)) e = 12'h444;
`endif
      @(negedge clk_pix);
      sx = 10'(x); sy = 10'(y); de = 1'b1; hsync = 1'b1; vsync = 1'b1;
      @(negedge clk_pix);
      idle();
      @(negedge clk_pix);
      chk(tag, {vga_r, vga_g, vga_b}, e);
   endtask

   task automatic frame_tick(input bit chk_strobe);
      @(negedge clk_pix);
      sx = 10'd0; sy = 10'd480; de = 1'b0; hsync = 1'b1; vsync = 1'b0;
      @(negedge clk_pix);
      idle();
      model_step();
      ticks++;
      if (chk_strobe) chk("frame_strobe", 12'(frame), 12'd1);
   endtask

   initial begin
      rst = 1'b1;
      mode = 2'd0;
      idle();
      model_reset();
      repeat (3) @(negedge clk_pix);
      chk("rst_hsync", 12'(vga_hsync), 12'd1);
      chk("rst_vsync", 12'(vga_vsync), 12'd1);
      chk("rst_de", 12'(vga_de), 12'd0);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      chk("rst_frame", 12'(frame), 12'd0);
      rst = 1'b0;

      // Colour bars straight out of reset.
      check_pix("bar_0_0", 0, 0, 12'hFFF);
      check_pix("bar_79", 79, 5, 12'hFFF);
      check_pix("bar_80", 80, 5, 12'hFF0);
      check_pix("bar_160", 160, 5, 12'h0FF);
      check_pix("bar_240", 240, 5, 12'h0F0);
      check_pix("bar_320", 320, 5, 12'hF0F);
      check_pix("bar_400", 400, 5, 12'hF00);
      check_pix("bar_480", 480, 5, 12'h00F);
      check_pix("bar_560", 560, 5, 12'h000);
      check_pix("bar_639", 639, 5, 12'h000);
      @(negedge clk_pix);
      sx = 10'd100; sy = 10'd5; de = 1'b0;
      @(negedge clk_pix);
      idle();
      @(negedge clk_pix);
      chk("de_gate", {vga_r, vga_g, vga_b}, 12'h000);
      @(negedge clk_pix);
      chk("frame_idle", 12'(frame), 12'd0);

      // Checkerboard and 2-cycle sync/de alignment over a full line.
      mode = 2'd1;
      frame_tick(1'b1);
      @(negedge clk_pix);
      chk("frame_one_cycle", 12'(frame), 12'd0);
      check_pix("chk_32_0", 32, 0, 12'hFFF);
      check_pix("chk_32_32", 32, 32, 12'h000);
      check_pix("chk_0_32", 0, 32, 12'hFFF);
      check_pix("chk_64_0", 64, 0, 12'h000);
      for (int c = 0; c < 802; c++) begin
         @(negedge clk_pix);
         if (c >= 2) begin
            logic [11:0] e;
            int x;
            x = c - 2;
            e = (x[5] == 1'b1) ? 12'hFFF : 12'h000;
`ifdef PATTERN_GRID_EN
            if (x % 32 == 0) e = 12'h444;
`endif
            if (!de_h[c-2]) e = 12'h000;
            chk("line_hsync", 12'(vga_hsync), 12'(hs_h[c-2]));
            chk("line_vsync", 12'(vga_vsync), 12'(vs_h[c-2]));
            chk("line_de", 12'(vga_de), 12'(de_h[c-2]));
            chk("line_rgb", {vga_r, vga_g, vga_b}, e);
         end
         if (c < 800) begin
            sx = 10'(c); sy = 10'd5;
            hsync = !(c >= 656 && c < 752);
            vsync = !(c >= 300 && c < 304);
            de = (c < 640);
            hs_h[c] = hsync; vs_h[c] = vsync; de_h[c] = de;
         end else begin
            idle();
         end
      end

      // Bouncing square; ticks counts updates since reset.
      mode = 2'd2;
      for (int f = 0; f < 399; f++) begin
         frame_tick(f < 3);
         if ((ticks % 25 == 0) || (mqx == 608) || (mqy == 448) || (mqx == 0) || (mqy == 0)) begin
            check_pix("sq_corner", mqx, mqy, 12'hFFF);
            check_pix("sq_right", mqx + 32, mqy, 12'h137);
         end
         if (ticks == 224) begin
            check_pix("sq_t224", 448, 448, 12'hFFF);
            check_pix("sq_t224_left", 447, 448, 12'h137);
            check_pix("sq_t224_above", 448, 447, 12'h137);
         end
         if (ticks == 304) begin
            check_pix("sq_t304", 608, 288, 12'hFFF);
            check_pix("sq_t304_left", 607, 288, 12'h137);
         end
         if (ticks == 305) begin
            check_pix("sq_t305", 606, 286, 12'hFFF);
            check_pix("sq_t305_right", 638, 286, 12'h137);
         end
         if (ticks == 400) begin
            check_pix("sq_t400", 416, 96, 12'hFFF);
            check_pix("sq_t400_left", 415, 96, 12'h137);
         end
      end

      // Mode change mid-frame holds until the next update point.
      mode = 2'd0;
      frame_tick(1'b1);
      mode = 2'd3;
      check_pix("hold_100", 80, 100, 12'hFF0);
      check_pix("hold_479", 0, 479, 12'hFFF);
      check_pix("hold_300", 560, 300, 12'h000);
      frame_tick(1'b1);
      check_pix("grey_0_0", 0, 0, 12'h888);
      check_pix("grey_100", 100, 100, 12'h888);

      // Reset mid-frame while driving an active pixel.
      mode = 2'd2;
      frame_tick(1'b1);
      @(negedge clk_pix);
      sx = 10'd300; sy = 10'd200; de = 1'b1; hsync = 1'b0; vsync = 1'b1;
      repeat (2) @(negedge clk_pix);
      chk("pre_rst_de", 12'(vga_de), 12'd1);
      chk("pre_rst_hsync", 12'(vga_hsync), 12'd0);
      chk("pre_rst_rgb", {vga_r, vga_g, vga_b}, 12'h137);
      rst = 1'b1;
      @(negedge clk_pix);
      chk("mid_rst_de", 12'(vga_de), 12'd0);
      chk("mid_rst_hsync", 12'(vga_hsync), 12'd1);
      chk("mid_rst_vsync", 12'(vga_vsync), 12'd1);
      chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
      chk("mid_rst_frame", 12'(frame), 12'd0);
      repeat (2) @(negedge clk_pix);
      rst = 1'b0;
      idle();
      model_reset();
      check_pix("post_rst_bars", 100, 0, 12'hFF0);
      frame_tick(1'b1);
      check_pix("post_rst_sq", 2, 2, 12'hFFF);
      check_pix("post_rst_sq_left", 1, 2, 12'h137);
      check_pix("post_rst_sq_right", 34, 2, 12'h137);

      // Grid overlay in bars mode (plain bar colour when the grid is not built).
      mode = 2'd0;
      frame_tick(1'b1);
`ifdef PATTERN_GRID_EN
      check_pix("grid_64_10", 64, 10, 12'h444);
`else
      check_pix("grid_64_10", 64, 10, 12'hFFF);
`endif
      check_pix("grid_65_10", 65, 10, 12'hFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
